neander_mem_responder: RTL and testbench

NEANDER_MEM_RESPONDER -- requirements
Module: neander_mem_responder

---
 rtl/neander_mem_responder.sv | 114 +++++++++++
 tb/tb_neander_mem_responder.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/neander_mem_responder.sv
// rtl/neander_mem_responder.sv - 256x8 wait-state memory responder for the Neander CPU memory port
//
// Optional feature macro: NEANDER_MEM_WPROT_EN (write protection below PROT_LIMIT).
//
// Ports:
//   i_clk    clock, rising edge
//   i_rst    synchronous active-high reset (memory contents are kept)
//   i_req    request strobe, sampled only while idle
//   i_we     1 = write, 0 = read
//   i_addr   word address (CPU REM)
//   i_wdata  write data (CPU RDM)
//   o_ack    one-cycle completion pulse
//   o_rdata  response data, valid with o_ack, held until the next memory operation
//   o_busy   high while a transaction is outstanding
//   o_err    rejected write flag, valid with o_ack, held like o_rdata

module neander_mem_responder #(
    parameter int         WAIT_STATES = 1,
    parameter logic [7:0] PROT_LIMIT  = 8'h80
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_req,
    input  logic       i_we,
    input  logic [7:0] i_addr,
    input  logic [7:0] i_wdata,
    output logic       o_ack,
    output logic [7:0] o_rdata,
    output logic       o_busy,
    output logic       o_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

`ifdef NEANDER_MEM_WPROT_EN
    localparam logic WPROT = 1'b1;
`else
    localparam logic WPROT = 1'b0;
`endif

    logic [1:0] state;
    logic [2:0] cnt;
    logic       we_q;
    logic [7:0] addr_q;
    logic [7:0] wdata_q;
    logic [7:0] mem [0:255];

    logic       op_now;
    logic       prot_hit;
    logic       commit;

    // The memory operation happens on the WAIT exit edge; reset on that
    // same edge must suppress the commit, hence the explicit !i_rst term.
    assign op_now   = (state == S_WAIT) && (cnt == 3'd0) && !i_rst;
    assign prot_hit = WPROT && (addr_q < PROT_LIMIT);
    assign commit   = op_now && we_q && !prot_hit;

    assign o_ack  = (state == S_RESP);
    assign o_busy = (state != S_IDLE);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= S_IDLE;
            cnt     <= 3'd0;
            we_q    <= 1'b0;
            addr_q  <= 8'h00;
            wdata_q <= 8'h00;
            o_rdata <= 8'h00;
            o_err   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_req) begin
                        state   <= S_WAIT;
                        cnt     <= 3'(WAIT_STATES);
                        we_q    <= i_we;
                        addr_q  <= i_addr;
                        wdata_q <= i_wdata;
                    end
                end
                S_WAIT: begin
                    if (cnt == 3'd0) begin
                        state <= S_RESP;
                        // A rejected write answers like a read of the old contents.
                        if (we_q && !prot_hit) begin
                            o_rdata <= wdata_q;
                        end else begin
                            o_rdata <= mem[addr_q];
                        end
                        o_err <= we_q && prot_hit;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Storage has no reset so contents survive i_rst.
    always_ff @(posedge i_clk) begin
        if (commit) begin
            mem[addr_q] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_neander_mem_responder.sv
// tb/tb_neander_mem_responder.sv - directed self-checking bench for neander_mem_responder
//
// Three instances (WAIT_STATES = 1, 0, 7) share the stimulus; index 0/1/2 of the
// observation vectors maps to WS1/WS0/WS7.

module tb_neander_mem_responder;

    logic       clk = 1'b0;
    logic       rst;
    logic       req;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;

    logic [2:0] ack;
    logic [2:0] busy;
    logic [2:0] err;
    logic [7:0] rdata [3];

    int n_cmp = 0;
    int n_err = 0;

    int         lat [3];
    logic [7:0] rd  [3];
    logic       er  [3];
    logic       bb  [3];

    always #5 clk = ~clk;

    neander_mem_responder #(.WAIT_STATES(1), .PROT_LIMIT(8'h80)) dut_ws1 (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_we(we), .i_addr(addr), .i_wdata(wdata),
        .o_ack(ack[0]), .o_rdata(rdata[0]), .o_busy(busy[0]), .o_err(err[0]));

    neander_mem_responder #(.WAIT_STATES(0), .PROT_LIMIT(8'h80)) dut_ws0 (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_we(we), .i_addr(addr), .i_wdata(wdata),
        .o_ack(ack[1]), .o_rdata(rdata[1]), .o_busy(busy[1]), .o_err(err[1]));

    neander_mem_responder #(.WAIT_STATES(7), .PROT_LIMIT(8'h80)) dut_ws7 (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_we(we), .i_addr(addr), .i_wdata(wdata),
        .o_ack(ack[2]), .o_rdata(rdata[2]), .o_busy(busy[2]), .o_err(err[2]));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One pulsed transaction; records per-instance ack latency (edges after
    // acceptance), response data and whether busy ever dropped before ack.
    task automatic txn(input logic w, input logic [7:0] a, input logic [7:0] d);
        req = 1'b1; we = w; addr = a; wdata = d;
        step();
        req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            lat[i] = 0;
            rd[i]  = 8'h00;
            er[i]  = 1'b0;
            bb[i]  = !busy[i];
        end
        for (int k = 1; k <= 12; k++) begin
            step();
            for (int i = 0; i < 3; i++) begin
                if (lat[i] == 0) begin
                    if (!busy[i]) bb[i] = 1'b1;
                    if (ack[i]) begin
                        lat[i] = k;
                        rd[i]  = rdata[i];
                        er[i]  = err[i];
                    end
                end
            end
        end
    endtask

    initial begin
        int n_ack;
        int t1;
        int t2;
        logic [7:0] r1;
        logic [7:0] r2;

        // Reset with a request pending: must be ignored.
        rst = 1'b1; req = 1'b1; we = 1'b1; addr = 8'hC0; wdata = 8'h77;
        step();
        step();
        check("rst_ack",   32'(ack),      32'h0);
        check("rst_busy",  32'(busy),     32'h0);
        check("rst_rdata", 32'(rdata[0]), 32'h00);
        check("rst_err",   32'(err),      32'h0);
        rst = 1'b0; req = 1'b0;
        step();
        check("rst_req_ignored", 32'(busy), 32'h0);

        // Write 5A to C0, then read it back.
        txn(1'b1, 8'hC0, 8'h5A);
        check("wr_lat_ws1", 32'(lat[0]), 32'd2);
        check("wr_rdata",   32'(rd[0]),  32'h5A);
        check("wr_err",     32'(er[0]),  32'h0);
        txn(1'b0, 8'hC0, 8'h00);
        check("rd_lat_ws1",  32'(lat[0]), 32'd2);
        check("rd_lat_ws0",  32'(lat[1]), 32'd1);
        check("rd_lat_ws7",  32'(lat[2]), 32'd8);
        check("rd_busy_ws0", 32'(bb[1]),  32'h0);
        check("rd_busy_ws7", 32'(bb[2]),  32'h0);
        check("rd_data_ws1", 32'(rd[0]),  32'h5A);
        check("rd_data_ws7", 32'(rd[2]),  32'h5A);
        check("rd_err",      32'(er[0]),  32'h0);
        check("rdata_hold",  32'(rdata[0]), 32'h5A);
        check("idle_after",  32'(busy),   32'h0);

        txn(1'b1, 8'h10, 8'hA1);
        txn(1'b1, 8'h11, 8'hB2);

        // Second request while busy must be dropped.
        req = 1'b1; we = 1'b0; addr = 8'h10;
        step();
        addr = 8'h11;
        step();
        req = 1'b0;
        n_ack = 0; r1 = 8'h00;
        for (int k = 0; k < 12; k++) begin
            if (ack[0]) begin
                n_ack++;
                r1 = rdata[0];
            end
            step();
        end
        check("busy_ign_acks", 32'(n_ack), 32'd1);
        check("busy_ign_data", 32'(r1),    32'hA1);

        // Request held high: reads of 10 then 11, acks WS+3 apart.
        req = 1'b1; we = 1'b0; addr = 8'h10;
        step();
        addr = 8'h11;
        n_ack = 0; t1 = 0; t2 = 0; r1 = 8'h00; r2 = 8'h00;
        for (int k = 1; k <= 14; k++) begin
            step();
            if (ack[0]) begin
                if (n_ack == 0) begin
                    t1 = k; r1 = rdata[0];
                end else begin
                    t2 = k; r2 = rdata[0];
                end
                n_ack++;
                if (n_ack == 2) req = 1'b0;
            end
        end
        req = 1'b0;
        check("b2b_acks",    32'(n_ack),   32'd2);
        check("b2b_first",   32'(t1),      32'd2);
        check("b2b_spacing", 32'(t2 - t1), 32'd4);
        check("b2b_data1",   32'(r1),      32'hA1);
        check("b2b_data2",   32'(r2),      32'hB2);

        // Reset on the commit edge aborts the write.
        txn(1'b1, 8'hD0, 8'h3C);
        req = 1'b1; we = 1'b1; addr = 8'hD0; wdata = 8'hFF;
        step();
        req = 1'b0;
        step();
        check("abort_pre_ack", 32'(ack[0]), 32'h0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_ack",   32'(ack[0]),   32'h0);
        check("abort_busy",  32'(busy[0]),  32'h0);
        check("abort_rdata", 32'(rdata[0]), 32'h00);
        n_ack = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (ack[0]) n_ack++;
        end
        check("abort_no_ack", 32'(n_ack), 32'd0);
        txn(1'b0, 8'hD0, 8'h00);
        check("abort_old_ws1", 32'(rd[0]), 32'h3C);
        check("abort_old_ws7", 32'(rd[2]), 32'h3C);

        // Write to a low address.
`ifdef NEANDER_MEM_WPROT_EN
        dut_ws1.mem[8'h05] = 8'h11;
        dut_ws0.mem[8'h05] = 8'h11;
        dut_ws7.mem[8'h05] = 8'h11;
        txn(1'b1, 8'h05, 8'h33);
        check("prot_err",   32'(er[0]), 32'h1);
        check("prot_rdata", 32'(rd[0]), 32'h11);
        check("prot_hold",  32'(err[0]), 32'h1);
        txn(1'b0, 8'h05, 8'h00);
        check("prot_read",     32'(rd[0]), 32'h11);
        check("prot_read_err", 32'(er[0]), 32'h0);
`else
        txn(1'b1, 8'h05, 8'h11);
        txn(1'b1, 8'h05, 8'h33);
        check("noprot_err",   32'(er[0]), 32'h0);
        check("noprot_rdata", 32'(rd[0]), 32'h33);
        txn(1'b0, 8'h05, 8'h00);
        check("noprot_read",     32'(rd[0]), 32'h33);
        check("noprot_read_err", 32'(er[0]), 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
